// File: rtl/rv_lsu.sv
// Load/store unit: drives a req/ack data bus for loads and stores, extends load data,
// and forwards ALU results to writeback with the same single-cycle latency.
module rv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_WIDTH       = 9
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic [31:0] i_add,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wsel,
  input  logic        i_store,
  input  logic        i_load,
  input  logic [2:0]  i_funct3,
  input  logic        i_reg_write,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_result,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_addr,
  output logic [3:0]  o_dbus_sel,
  output logic [31:0] o_dbus_wdata,
  input  logic        i_dbus_ack,
  input  logic [31:0] i_dbus_rdata,
  output logic        o_stall,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_we,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {IDLE, BUS, WAIT_DRAIN} state_e;

  localparam logic [TO_WIDTH-1:0] ToLast =
    TO_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

  state_e              state_q;
  logic                req_q, we_q, stall_q;
  logic [31:0]         addr_q, wdata_q;
  logic [3:0]          sel_q;
  logic [2:0]          funct3_q;
  logic [4:0]          rd_q;
  logic                regw_q, flushed_q;
  logic [1:0]          off_q;
  logic [TO_WIDTH-1:0] cnt_q;
  logic [31:0]         wb_data_q;
  logic [4:0]          wb_rd_q;
  logic                wb_we_q, mis_q, err_q;

  logic        misaligned_d;
  logic [7:0]  lane_b_d;
  logic [15:0] lane_h_d;
  logic [31:0] load_data_d;

  always_comb begin
    misaligned_d = 1'b0;
    case (i_funct3[1:0])
      2'd1:    misaligned_d = i_add[0];
      2'd2:    misaligned_d = |i_add[1:0];
      default: misaligned_d = 1'b0;
    endcase
  end

  // Lane selection uses the byte offset captured at accept time, not the live address.
  always_comb begin
    lane_b_d    = 8'h00;
    lane_h_d    = off_q[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
    load_data_d = i_dbus_rdata;
    case (off_q)
      2'd0:    lane_b_d = i_dbus_rdata[7:0];
      2'd1:    lane_b_d = i_dbus_rdata[15:8];
      2'd2:    lane_b_d = i_dbus_rdata[23:16];
      default: lane_b_d = i_dbus_rdata[31:24];
    endcase
    case (funct3_q[1:0])
      2'd0:    load_data_d = funct3_q[2] ? {24'h0, lane_b_d} : {{24{lane_b_d[7]}}, lane_b_d};
      2'd1:    load_data_d = funct3_q[2] ? {16'h0, lane_h_d} : {{16{lane_h_d[15]}}, lane_h_d};
      default: load_data_d = i_dbus_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      stall_q   <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      sel_q     <= 4'h0;
      funct3_q  <= 3'h0;
      rd_q      <= 5'h0;
      regw_q    <= 1'b0;
      flushed_q <= 1'b0;
      off_q     <= 2'h0;
      cnt_q     <= '0;
      wb_data_q <= 32'h0;
      wb_rd_q   <= 5'h0;
      wb_we_q   <= 1'b0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wb_we_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_flush) begin
            wb_we_q <= 1'b0;
          end else if (i_load || i_store) begin
            if (misaligned_d) begin
              mis_q <= 1'b1;
            end else begin
              addr_q    <= {i_add[31:2], 2'b00};
              sel_q     <= i_store ? i_wsel : 4'hF;
              wdata_q   <= i_wdata;
              we_q      <= i_store;
              funct3_q  <= i_funct3;
              rd_q      <= i_rd;
              regw_q    <= i_reg_write;
              off_q     <= i_add[1:0];
              flushed_q <= 1'b0;
              cnt_q     <= '0;
              req_q     <= 1'b1;
              stall_q   <= 1'b1;
              state_q   <= BUS;
            end
          end else begin
            wb_data_q <= i_result;
            wb_rd_q   <= i_rd;
            wb_we_q   <= i_reg_write;
          end
        end
        BUS: begin
          if (i_flush) flushed_q <= 1'b1;
          if (i_dbus_ack) begin
            req_q   <= 1'b0;
            stall_q <= 1'b0;
            state_q <= IDLE;
            if (!we_q && !flushed_q && !i_flush) begin
              wb_data_q <= load_data_d;
              wb_rd_q   <= rd_q;
              wb_we_q   <= regw_q;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == ToLast)) begin
            req_q   <= 1'b0;
            stall_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= WAIT_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // One dead cycle so a straggling ack lands while req is low and is ignored.
        WAIT_DRAIN: state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  assign o_dbus_req   = req_q;
  assign o_dbus_we    = we_q;
  assign o_dbus_addr  = addr_q;
  assign o_dbus_sel   = sel_q;
  assign o_dbus_wdata = wdata_q;
  assign o_stall      = stall_q;
  assign o_wb_data    = wb_data_q;
  assign o_wb_rd      = wb_rd_q;
  assign o_wb_we      = wb_we_q;
  assign o_misaligned = mis_q;
  assign o_bus_err    = err_q;

endmodule
